// File: rtl/hack_alu_pkg.sv
// Shared types and helpers for the registered Hack ALU: sequencer states,
// the control bundle layout and the per-bit operand preprocessing rule.
package hack_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
        logic mul;
    } alu_ctrl_t;

    // Zero the bit when z is set, then invert it when n is set.
    function automatic logic pre_bit(input logic z, input logic n, input logic b);
        return n ^ (b & ~z);
    endfunction

endpackage

// File: rtl/hack_alu_comb.sv
// Combinational Hack ALU datapath, WIDTH bits wide: operand preprocessing,
// add/and, output inversion and the zr/ng/cy flags of the final result.
module hack_alu_comb
    import hack_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] px,
    output logic [WIDTH-1:0] py,
    output logic [WIDTH-1:0] res,
    output logic             zr,
    output logic             ng,
    output logic             cy
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;

    always_comb begin
        px = '0;
        py = '0;
        for (int i = 0; i < WIDTH; i++) begin
            px[i] = pre_bit(zx, nx, x[i]);
            py[i] = pre_bit(zy, ny, y[i]);
        end
    end

    assign sum = {1'b0, px} + {1'b0, py};

    // The carry belongs to the raw sum, so it is unaffected by the no inversion.
    always_comb begin
        r  = '0;
        cy = 1'b0;
        if (f) begin
            r  = sum[WIDTH-1:0];
            cy = sum[WIDTH];
        end else begin
            r  = px & py;
        end
        res = no ? ~r : r;
        zr  = (res == '0);
        ng  = res[WIDTH-1];
    end

endmodule

// File: rtl/hack_alu_seq.sv
// Registered Hack ALU with valid/ready on both sides. Define HACK_ALU_MUL_EN
// to add the multi-cycle shift-add multiplier selected by the mul input.
module hack_alu_seq
    import hack_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    input  logic             mul,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             cy,
    output logic [1:0]       dbg_state
);

    alu_state_t       state;
    alu_ctrl_t        ctrl;
    logic             accept;
    logic [WIDTH-1:0] px;
    logic [WIDTH-1:0] py;
    logic [WIDTH-1:0] res;
    logic             res_zr;
    logic             res_ng;
    logic             res_cy;

    assign ctrl = {zx, nx, zy, ny, f, no, mul};

    hack_alu_comb #(.WIDTH(WIDTH)) u_comb (
        .x   (x),
        .y   (y),
        .zx  (ctrl.zx),
        .nx  (ctrl.nx),
        .zy  (ctrl.zy),
        .ny  (ctrl.ny),
        .f   (ctrl.f),
        .no  (ctrl.no),
        .px  (px),
        .py  (py),
        .res (res),
        .zr  (res_zr),
        .ng  (res_ng),
        .cy  (res_cy)
    );

    // Handshake: a bundle transfers on a rising edge where in_valid && in_ready;
    // a result transfers where out_valid && out_ready. A pending result is held
    // unchanged until taken, and a slot frees up the same edge it is taken.
    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign dbg_state = state;

`ifdef HACK_ALU_MUL_EN
    logic             mul_sel;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] mul_res;
    logic [CNT_W-1:0] cnt;
    logic             mul_no;

    assign mul_sel = ctrl.mul;

    // Only the low WIDTH bits of the product are kept, so the shifted
    // multiplicand may drop its upper bits without changing the result.
    always_comb begin
        acc_step = mplier[0] ? (acc + mcand) : acc;
        mul_res  = mul_no ? ~acc_step : acc_step;
    end
`else
    logic unused_ok;
    assign unused_ok = ^{ctrl.mul, px, py};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out       <= '0;
            zr        <= 1'b1;
            ng        <= 1'b0;
            cy        <= 1'b0;
`ifdef HACK_ALU_MUL_EN
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            mul_no    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
`ifdef HACK_ALU_MUL_EN
                        if (mul_sel) begin
                            state     <= BUSY;
                            out_valid <= 1'b0;
                            mcand     <= px;
                            mplier    <= py;
                            acc       <= '0;
                            cnt       <= '0;
                            mul_no    <= ctrl.no;
                        end else
`endif
                        begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out       <= res;
                            zr        <= res_zr;
                            ng        <= res_ng;
                            cy        <= res_cy;
                        end
                    end else if (state == DONE && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
`ifdef HACK_ALU_MUL_EN
                BUSY: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out       <= mul_res;
                        zr        <= (mul_res == '0);
                        ng        <= mul_res[WIDTH-1];
                        cy        <= 1'b0;
                    end
                end
`endif
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hack_alu_seq.sv
// Directed plus random bench for hack_alu_seq, checked against a plain
// arithmetic reference model and an expected-result queue.
module tb_hack_alu_seq;

    localparam int W = 16;
    localparam longint unsigned MASK = (64'd1 << W) - 64'd1;
`ifdef HACK_ALU_MUL_EN
    localparam bit MUL = 1'b1;
`else
    localparam bit MUL = 1'b0;
`endif

    // {zx,nx,zy,ny,f,no,mul}
    localparam logic [6:0] C_ADD = 7'b0000100;
    localparam logic [6:0] C_ZERO = 7'b1010100;
    localparam logic [6:0] C_ONE = 7'b1111110;
    localparam logic [6:0] C_NEG1 = 7'b1110100;
    localparam logic [6:0] C_MUL = 7'b0000001;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         zx, nx, zy, ny, f, no, mul;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         zr, ng, cy;
    logic [1:0]   dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [W:0] exp_q[$];
    logic       pend_valid = 1'b0;
    int         mul_left = 0;

    hack_alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .zx        (zx),
        .nx        (nx),
        .zy        (zy),
        .ny        (ny),
        .f         (f),
        .no        (no),
        .mul       (mul),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zr        (zr),
        .ng        (ng),
        .cy        (cy),
        .dbg_state (dbg_state)
    );

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: returns {carry, result}
    function automatic logic [W:0] model(input logic [W-1:0] xi, input logic [W-1:0] yi,
                                         input logic [6:0] c);
        longint unsigned a, b, r, full;
        logic cyo;
        cyo = 1'b0;
        a = c[6] ? 64'd0 : longint'(xi);
        if (c[5]) a = ~a & MASK;
        b = c[4] ? 64'd0 : longint'(yi);
        if (c[3]) b = ~b & MASK;
        if (MUL && c[0]) begin
            r = (a * b) & MASK;
        end else if (c[2]) begin
            full = a + b;
            r = full & MASK;
            cyo = (full >> W) != 0;
        end else begin
            r = a & b;
        end
        if (c[1]) r = ~r & MASK;
        return {cyo, W'(r)};
    endfunction

    // driver: one clock of stimulus, then check outputs against the scoreboard
    task automatic cycle(input logic v, input logic [W-1:0] xi, input logic [W-1:0] yi,
                         input logic [6:0] c, input logic rdy);
        logic       exp_ready;
        logic [W:0] e;
        in_valid = v;
        x = xi;
        y = yi;
        {zx, nx, zy, ny, f, no, mul} = c;
        out_ready = rdy;
        #1;
        exp_ready = (mul_left == 0) && (!pend_valid || rdy);
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        @(posedge clk);
        if (pend_valid && rdy) begin
            e = exp_q.pop_front();
            pend_valid = 1'b0;
        end
        if (mul_left > 0) begin
            mul_left--;
            if (mul_left == 0) pend_valid = 1'b1;
        end else if (v && exp_ready) begin
            exp_q.push_back(model(xi, yi, c));
            if (MUL && c[0]) mul_left = W;
            else pend_valid = 1'b1;
        end
        #1;
        check("out_valid", {31'd0, out_valid}, {31'd0, pend_valid});
        if (pend_valid && exp_q.size() > 0) begin
            e = exp_q[0];
            check("out", {16'd0, out}, {16'd0, e[W-1:0]});
            check("zr", {31'd0, zr}, {31'd0, (e[W-1:0] == '0)});
            check("ng", {31'd0, ng}, {31'd0, e[W-1]});
            check("cy", {31'd0, cy}, {31'd0, e[W]});
        end
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock.
    task automatic async_reset(input string tag);
        in_valid = 1'b0;
        out_ready = 1'b1;
        reset = 1'b1;
        #1;
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out"}, {16'd0, out}, 32'd0);
        check({tag, "_zr"}, {31'd0, zr}, 32'd1);
        check({tag, "_ng"}, {31'd0, ng}, 32'd0);
        check({tag, "_cy"}, {31'd0, cy}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        pend_valid = 1'b0;
        mul_left = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int lat;
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        x = '0;
        y = '0;
        {zx, nx, zy, ny, f, no, mul} = 7'd0;
        @(posedge clk);
        #1;
        async_reset("por");

        // basic add and wrap with carry
        cycle(1'b1, 16'h0005, 16'h0003, C_ADD, 1'b1);
        check("add_5_3", {16'd0, out}, 32'h0008);
        check("add_5_3_cy", {31'd0, cy}, 32'd0);
        cycle(1'b1, 16'hFFFF, 16'h0001, C_ADD, 1'b1);
        check("add_wrap", {16'd0, out}, 32'h0000);
        check("add_wrap_zr", {31'd0, zr}, 32'd1);
        check("add_wrap_cy", {31'd0, cy}, 32'd1);

        // Hack constant encodings, one per cycle
        cycle(1'b1, W'($urandom), W'($urandom), C_ZERO, 1'b1);
        check("const_0", {16'd0, out}, 32'h0000);
        cycle(1'b1, W'($urandom), W'($urandom), C_ONE, 1'b1);
        check("const_1", {16'd0, out}, 32'h0001);
        cycle(1'b1, W'($urandom), W'($urandom), C_NEG1, 1'b1);
        check("const_m1", {16'd0, out}, 32'hFFFF);
        check("const_m1_ng", {31'd0, ng}, 32'd1);

        async_reset("mid");

        // back-pressure: result held, new bundle refused, then back-to-back reload
        cycle(1'b1, 16'h1230, 16'h0004, C_ADD, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, W'($urandom), W'($urandom), C_ADD, 1'b0);
            check("stall_out", {16'd0, out}, 32'h1234);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        cycle(1'b1, 16'h0001, 16'h0001, C_ADD, 1'b1);
        check("reload_out", {16'd0, out}, 32'h0002);
        cycle(1'b0, '0, '0, C_ADD, 1'b1);

`ifdef HACK_ALU_MUL_EN
        // 7 * -3: accept edge plus WIDTH busy edges
        cycle(1'b1, 16'h0007, 16'hFFFD, C_MUL, 1'b1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            cycle(1'b0, '0, '0, C_ADD, 1'b1);
            lat++;
        end
        check("mul_latency", lat, W);
        check("mul_out", {16'd0, out}, 32'hFFEB);
        check("mul_ng", {31'd0, ng}, 32'd1);
        check("mul_cy", {31'd0, cy}, 32'd0);
        cycle(1'b0, '0, '0, C_ADD, 1'b1);

        // abort a multiply partway, then a fresh one must start clean
        cycle(1'b1, 16'h1234, 16'h5678, C_MUL, 1'b1);
        repeat (4) cycle(1'b0, '0, '0, C_ADD, 1'b1);
        async_reset("busy");
        cycle(1'b1, 16'h0100, 16'h0100, C_MUL, 1'b1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            cycle(1'b0, '0, '0, C_ADD, 1'b1);
            lat++;
        end
        check("mul2_latency", lat, W);
        check("mul2_out", {16'd0, out}, 32'h0000);
        check("mul2_zr", {31'd0, zr}, 32'd1);
        cycle(1'b0, '0, '0, C_ADD, 1'b1);
`else
        // mul select has no effect in this build
        cycle(1'b1, 16'h0003, 16'h0004, C_ADD | C_MUL, 1'b1);
        check("mul_ignored", {16'd0, out}, 32'h0007);
        cycle(1'b0, '0, '0, C_ADD, 1'b1);
`endif

        // random traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            logic [6:0] c;
            c = 7'($urandom);
            c[0] = ($urandom_range(0, 7) == 0);
            cycle($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), c,
                  $urandom_range(0, 3) != 0);
        end
        repeat (W + 3) cycle(1'b0, '0, '0, C_ADD, 1'b1);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
